// File: rtl/pm_load_sequencer.sv
// Program memory sequencer: switch loader fills PM, appends a terminator,
// then hands the PM port to core fetch; owns halt, restart and reload.
module pm_load_sequencer #(
  parameter int unsigned PMAW = 8,
  parameter int unsigned OPW = 4,
  parameter logic [OPW-1:0] END_OP = 4'hF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load_strobe,
  input  logic            PMInputDone,
  input  logic [OPW-1:0]  switches,
  input  logic            go,
  input  logic            reload,
  input  logic            core_halt,
  input  logic [PMAW-1:0] core_fetch_addr,
  output logic [PMAW-1:0] pm_addr,
  output logic [OPW-1:0]  pm_wdata,
  output logic            pm_wren,
  output logic            core_run,
  output logic            core_restart,
  output logic [PMAW-1:0] prog_len,
  output logic            overflow
);

  typedef enum logic [1:0] {
    LOAD,
    TERM,
    RUN,
    HALT
  } seqStateE;

  localparam logic [PMAW-1:0] LAST = '1;

  seqStateE state;
  seqStateE nextState;

  logic strobeQ;
  logic doneQ;
  logic goQ;
  logic reloadQ;

  logic strobeEdge;
  logic doneEdge;
  logic goEdge;
  logic reloadEdge;

  logic [PMAW-1:0] wrPtr;
  logic            wrValid;
  logic [PMAW-1:0] wrAddr;
  logic [OPW-1:0]  wrData;
  logic [PMAW-1:0] lastAddr;
  logic [PMAW-1:0] progLenQ;
  logic            overflowQ;
  logic            restartQ;

  // Copies reset high so a level held through reset is not an edge
  assign strobeEdge = load_strobe & ~strobeQ;
  assign doneEdge   = PMInputDone & ~doneQ;
  assign goEdge     = go & ~goQ;
  assign reloadEdge = reload & ~reloadQ;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= nextState;
    end
  end

  // TERM waits out an opcode write captured alongside the done edge
  always_comb begin
    nextState = state;
    unique case (state)
      LOAD: begin
        if (doneEdge) begin
          nextState = TERM;
        end
      end
      TERM: begin
        if (!wrValid) begin
          nextState = RUN;
        end
      end
      RUN: begin
        if (core_halt) begin
          nextState = HALT;
        end
      end
      HALT: begin
        if (reloadEdge) begin
          nextState = LOAD;
        end else if (goEdge) begin
          nextState = RUN;
        end
      end
    endcase
  end

  always_comb begin
    pm_addr  = lastAddr;
    pm_wdata = wrData;
    pm_wren  = 1'b0;
    core_run = 1'b0;
    unique case (state)
      LOAD: begin
        pm_addr = wrAddr;
        pm_wren = wrValid;
      end
      TERM: begin
        pm_wren = 1'b1;
        if (wrValid) begin
          pm_addr = wrAddr;
        end else begin
          pm_addr  = wrPtr;
          pm_wdata = END_OP;
        end
      end
      RUN: begin
        pm_addr  = core_fetch_addr;
        core_run = 1'b1;
      end
      HALT: begin
        core_run = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      strobeQ   <= 1'b1;
      doneQ     <= 1'b1;
      goQ       <= 1'b1;
      reloadQ   <= 1'b1;
      wrPtr     <= '0;
      wrValid   <= 1'b0;
      wrAddr    <= '0;
      wrData    <= '0;
      lastAddr  <= '0;
      progLenQ  <= '0;
      overflowQ <= 1'b0;
      restartQ  <= 1'b0;
    end else begin
      strobeQ  <= load_strobe;
      doneQ    <= PMInputDone;
      goQ      <= go;
      reloadQ  <= reload;
      wrValid  <= 1'b0;
      restartQ <= 1'b0;
      lastAddr <= pm_addr;
      // The last address stays free for the terminator
      if (state == LOAD && strobeEdge) begin
        if (wrPtr != LAST) begin
          wrValid <= 1'b1;
          wrAddr  <= wrPtr;
          wrData  <= switches;
          wrPtr   <= wrPtr + PMAW'(1);
        end else begin
          overflowQ <= 1'b1;
        end
      end
      if (state == TERM && !wrValid) begin
        progLenQ <= wrPtr;
      end
      if (nextState == RUN && state != RUN) begin
        restartQ <= 1'b1;
      end
      if (state == HALT && reloadEdge) begin
        wrPtr     <= '0;
        progLenQ  <= '0;
        overflowQ <= 1'b0;
      end
    end
  end

  assign core_restart = restartQ;
  assign prog_len     = progLenQ;
  assign overflow     = overflowQ;

endmodule

// File: tb/tb_pm_load_sequencer.sv
// Directed bench for pm_load_sequencer (PMAW=3) with a write-queue
// reference model checked every cycle plus literal expectations.
module tb_pm_load_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_strobe = 1'b0;
  logic       PMInputDone = 1'b0;
  logic [3:0] switches = 4'h0;
  logic       go = 1'b0;
  logic       reload = 1'b0;
  logic       core_halt = 1'b0;
  logic [2:0] core_fetch_addr = 3'd0;
  logic [2:0] pm_addr;
  logic [3:0] pm_wdata;
  logic       pm_wren;
  logic       core_run;
  logic       core_restart;
  logic [2:0] prog_len;
  logic       overflow;

  pm_load_sequencer #(.PMAW(3), .OPW(4), .END_OP(4'hF)) dut (
    .clock(clock),
    .reset(reset),
    .load_strobe(load_strobe),
    .PMInputDone(PMInputDone),
    .switches(switches),
    .go(go),
    .reload(reload),
    .core_halt(core_halt),
    .core_fetch_addr(core_fetch_addr),
    .pm_addr(pm_addr),
    .pm_wdata(pm_wdata),
    .pm_wren(pm_wren),
    .core_run(core_run),
    .core_restart(core_restart),
    .prog_len(prog_len),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endfunction

  // Reference model: writes are queued in the order the rules demand
  // and drained one per cycle; run begins the cycle after the terminator.
  typedef struct {
    int a;
    logic [3:0] d;
    bit t;
  } wrT;

  wrT  wq[$];
  int  mMode = 0;
  bit  termSeen = 0;
  int  termAddr = 0;
  int  mPtr = 0;
  int  mLen = 0;
  bit  mOvf = 0;
  int  mHold = 0;
  bit  eWren = 0;
  bit  eRun = 0;
  bit  eRst = 0;
  bit  eReset = 0;
  int  eAddr = 0;
  logic [3:0] eData = 4'h0;
  bit  pS = 1, pD = 1, pG = 1, pR = 1;

  always @(posedge clock) begin
    bit sE, dE, gE, rE;
    wrT w;
    if (reset) begin
      wq.delete();
      mMode = 0; termSeen = 0; mPtr = 0; mLen = 0; mOvf = 0;
      eWren = 0; eRun = 0; eRst = 0; eReset = 1;
      pS = 1; pD = 1; pG = 1; pR = 1;
    end else begin
      sE = load_strobe && !pS;
      dE = PMInputDone && !pD;
      gE = go && !pG;
      rE = reload && !pR;
      eWren = 0; eRst = 0; eReset = 0;
      case (mMode)
        0: begin
          if (sE) begin
            if (mPtr < 7) begin
              w.a = mPtr; w.d = switches; w.t = 0;
              wq.push_back(w);
              mPtr++;
            end else begin
              mOvf = 1;
            end
          end
          if (dE) begin
            w.a = mPtr; w.d = 4'hF; w.t = 1;
            wq.push_back(w);
            mMode = 1;
          end
        end
        1: if (termSeen) begin
          mMode = 2; eRst = 1; termSeen = 0; mLen = termAddr;
        end
        2: if (core_halt) begin
          mMode = 3; mHold = core_fetch_addr;
        end
        default: begin
          if (rE) begin
            mMode = 0; mPtr = 0; mLen = 0; mOvf = 0;
          end else if (gE) begin
            mMode = 2; eRst = 1;
          end
        end
      endcase
      if (mMode < 2 && wq.size() > 0) begin
        w = wq.pop_front();
        eWren = 1; eAddr = w.a; eData = w.d;
        if (w.t) begin
          termSeen = 1; termAddr = w.a;
        end
      end
      eRun = (mMode == 2);
      pS = load_strobe; pD = PMInputDone; pG = go; pR = reload;
    end
  end

  logic [3:0] bpm [8];
  int wrCount = 0;
  int rstCount = 0;

  always @(negedge clock) begin
    chk("wren", pm_wren, eWren);
    if (eWren) begin
      chk("waddr", pm_addr, eAddr);
      chk("wdata", pm_wdata, eData);
    end
    chk("run", core_run, eRun);
    chk("restart", core_restart, eRst);
    chk("proglen", prog_len, mLen);
    chk("overflow", overflow, mOvf);
    if (eReset) begin
      chk("rstAddr", pm_addr, 0);
      chk("rstWdata", pm_wdata, 0);
    end
    if (mMode == 2) chk("fetchAddr", pm_addr, core_fetch_addr);
    if (mMode == 3) chk("haltAddr", pm_addr, mHold);
    if (pm_wren && core_run) chk("wrenRun", 1, 0);
    if (pm_wren) begin
      bpm[pm_addr] = pm_wdata;
      wrCount++;
    end
    if (core_restart) rstCount++;
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic strobe(logic [3:0] op);
    switches = op;
    load_strobe = 1'b1;
    cyc(1);
    load_strobe = 1'b0;
    cyc(1);
  endtask

  task automatic doneP();
    PMInputDone = 1'b1;
    cyc(1);
    PMInputDone = 1'b0;
    cyc(1);
  endtask

  task automatic haltP();
    core_halt = 1'b1;
    cyc(1);
    core_halt = 1'b0;
    cyc(2);
  endtask

  task automatic reloadP();
    reload = 1'b1;
    cyc(1);
    reload = 1'b0;
    cyc(1);
  endtask

  initial begin
    int w0;
    load_strobe = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    chk("heldStrobe", wrCount, 0);
    load_strobe = 1'b0;
    cyc(1);

    strobe(4'h1);
    strobe(4'h3);
    strobe(4'h2);
    doneP();
    cyc(3);
    chk("pm0", bpm[0], 4'h1);
    chk("pm1", bpm[1], 4'h3);
    chk("pm2", bpm[2], 4'h2);
    chk("pm3", bpm[3], 4'hF);
    chk("len3", prog_len, 3);
    chk("runOn", core_run, 1);
    chk("oneRestart", rstCount, 1);

    w0 = wrCount;
    for (int a = 0; a < 4; a++) begin
      core_fetch_addr = 3'(a);
      #1;
      chk("sweep", pm_addr, a);
      cyc(1);
    end
    strobe(4'h9);
    doneP();
    chk("runIgnore", wrCount, w0);

    haltP();
    chk("haltRun", core_run, 0);
    go = 1'b1;
    cyc(1);
    go = 1'b0;
    cyc(2);
    chk("goRun", core_run, 1);
    chk("goRestart", rstCount, 2);

    haltP();
    go = 1'b1;
    reload = 1'b1;
    cyc(1);
    go = 1'b0;
    reload = 1'b0;
    cyc(2);
    chk("reloadWins", core_run, 0);
    chk("reloadLen", prog_len, 0);
    chk("reloadOvf", overflow, 0);

    strobe(4'h7);
    strobe(4'h8);
    switches = 4'h5;
    load_strobe = 1'b1;
    PMInputDone = 1'b1;
    cyc(1);
    load_strobe = 1'b0;
    PMInputDone = 1'b0;
    cyc(5);
    chk("samePm2", bpm[2], 4'h5);
    chk("samePm3", bpm[3], 4'hF);
    chk("sameLen", prog_len, 3);

    haltP();
    reloadP();
    for (int i = 1; i <= 8; i++) strobe(4'(i));
    chk("ovfSet", overflow, 1);
    chk("ovfPm6", bpm[6], 4'h7);
    doneP();
    cyc(3);
    chk("ovfPm7", bpm[7], 4'hF);
    chk("ovfLen", prog_len, 7);

    haltP();
    reloadP();
    for (int i = 0; i < 4; i++) strobe(4'h3);
    switches = 4'hA;
    load_strobe = 1'b1;
    cyc(1);
    chk("midWrite", pm_wren, 1);
    reset = 1'b1;
    load_strobe = 1'b0;
    cyc(1);
    chk("rstWren", pm_wren, 0);
    reset = 1'b0;
    cyc(1);
    strobe(4'h6);
    chk("rstPtr", bpm[0], 4'h6);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
